// File: rtl/mem_bus_bridge.sv
// Load/store bridge: req/ack handshake to a synchronous word RAM with programmable
// wait states, plus a 16-byte MMIO window (LED, free-running cycle counter, WS CSR).
module mem_bus_bridge #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_SIZE    = 4096,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 'h8000_0000,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [7:0]            leds_o,
  output logic                  bus_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_LATCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_is_wr;
  logic [3:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [7:0]              r_leds;
  logic [31:0]             r_cycle;
  logic [3:0]              r_ws;
  logic                    r_bus_err;

  logic                    w_is_ram;
  logic                    w_is_mmio;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic [DATA_WIDTH-1:0]   w_mmio_rd;

  // Decode always works on the latched address; RAM wins if the windows overlap.
  assign w_off     = r_addr - MMIO_BASE;
  assign w_is_ram  = r_addr < ADDR_WIDTH'(MEM_SIZE);
  assign w_is_mmio = !w_is_ram && (w_off < ADDR_WIDTH'(16));

  always_comb begin
    w_mmio_rd = '0;
    case (w_off[3:2])
      2'd0:    w_mmio_rd = DATA_WIDTH'(r_leds);
      2'd1:    w_mmio_rd = DATA_WIDTH'(r_cycle);
      2'd2:    w_mmio_rd = DATA_WIDTH'(r_ws);
      default: w_mmio_rd = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (rd_en_i || wr_en_i) w_next = S_ACCESS;
      S_ACCESS: w_next = S_LATCH;
      S_LATCH:  w_next = (r_cnt == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so a reset cycle clears ack and strobes at once.
  always_comb begin
    ack_o       = 1'b0;
    data_o      = '0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    case (r_state)
      S_ACCESS: begin
        mem_rd_en_o = w_is_ram && !r_is_wr;
        mem_wr_en_o = w_is_ram &&  r_is_wr;
      end
      S_RESP: begin
        ack_o  = 1'b1;
        data_o = r_rdata;
      end
      default: ;
    endcase
  end

  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;
  assign leds_o     = r_leds;
  assign bus_err_o  = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_cnt     <= 4'd0;
      r_rdata   <= '0;
      r_leds    <= 8'd0;
      r_cycle   <= 32'd0;
      r_ws      <= 4'(WAIT_STATES);
      r_bus_err <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (rd_en_i || wr_en_i) begin
            r_addr  <= addr_i;
            r_wdata <= data_i;
            r_is_wr <= wr_en_i;
          end
        end
        S_ACCESS: begin
          // Counter takes the pre-write WS, so a CSR write only affects later transactions.
          r_cnt <= r_ws;
          if (!w_is_ram && !w_is_mmio) r_bus_err <= 1'b1;
          if (r_is_wr && w_is_mmio) begin
            case (w_off[3:2])
              2'd0:    r_leds <= r_wdata[7:0];
              2'd2:    r_ws   <= r_wdata[3:0];
              default: ;
            endcase
          end
        end
        S_LATCH: begin
          if (!r_is_wr) begin
            if (w_is_ram)       r_rdata <= mem_data_i;
            else if (w_is_mmio) r_rdata <= w_mmio_rd;
            else                r_rdata <= '0;
          end
        end
        S_WAIT:  r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge against a transaction-level model of the
// bridge's memory map, latency rule and sticky error flag.
module tb_mem_bus_bridge;
  localparam int          MS  = 4096;
  localparam logic [31:0] MB  = 32'h8000_0000;
  localparam int          WS0 = 1;

  logic        clk, rst;
  logic        rd_en_i, wr_en_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o, mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [7:0]  leds_o;
  logic        bus_err_o;

  mem_bus_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MS),
                   .MMIO_BASE(MB), .WAIT_STATES(WS0)) dut (
    .clk(clk), .rst(rst), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .ack_o(ack_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .leds_o(leds_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM behind the bridge: read data appears the cycle after the strobe.
  logic [31:0] ram [1024] = '{4: 32'hDEADBEEF, default: 32'h0};
  always @(posedge clk) begin
    if (mem_wr_en_o) ram[mem_addr_o[11:2]] <= mem_data_o;
    if (mem_rd_en_o) mem_data_i <= ram[mem_addr_o[11:2]];
  end

  // Reference state: RAM image, MMIO registers, error flag, cycles since reset.
  logic [31:0] ref_mem [1024] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [7:0]  m_leds;
  logic [3:0]  m_ws;
  logic        m_err;
  logic [31:0] cyc;
  logic [31:0] t_issue;
  always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction started in an IDLE cycle; returns read data.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdata);
    logic        is_wr, is_ram, is_mmio;
    logic [31:0] off, exp_rd, sa, sd, c0;
    int          lat, nrd, nwr, strk, exp_lat;
    is_wr   = wr;
    is_ram  = a < MS;
    off     = a - MB;
    is_mmio = !is_ram && (off < 32'd16);
    exp_lat = 3 + int'(m_ws);
    c0      = cyc;
    t_issue = c0;
    exp_rd  = 32'h0;
    if (is_ram) exp_rd = ref_mem[a[11:2]];
    else if (is_mmio) begin
      case (off[3:2])
        2'd0: exp_rd = {24'h0, m_leds};
        2'd1: exp_rd = c0 + 32'd2;
        2'd2: exp_rd = {28'h0, m_ws};
        default: exp_rd = 32'h0;
      endcase
    end
    rd_en_i = rd; wr_en_i = wr; addr_i = a; data_i = d;
    lat = 0; nrd = 0; nwr = 0; strk = 0; sa = 32'h0; sd = 32'h0; rdata = 32'hx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_rd_en_o) begin nrd++; strk = k; sa = mem_addr_o; end
      if (mem_wr_en_o) begin nwr++; strk = k; sa = mem_addr_o; sd = mem_data_o; end
      if (ack_o) begin lat = k; rdata = data_o; break; end
    end
    rd_en_i = 1'b0; wr_en_i = 1'b0;
    @(negedge clk);
    chk("latency", lat, exp_lat);
    chk("rd_strobes", nrd, {31'h0, is_ram && !is_wr});
    chk("wr_strobes", nwr, {31'h0, is_ram && is_wr});
    if (is_ram) begin
      chk("strobe_cycle", strk, 1);
      chk("mem_addr", sa, a);
    end
    if (is_ram && is_wr) chk("mem_wdata", sd, d);
    if (!is_wr) chk("rdata", rdata, exp_rd);
    if (is_wr) begin
      if (is_ram) ref_mem[a[11:2]] = d;
      else if (is_mmio && off[3:2] == 2'd0) m_leds = d[7:0];
      else if (is_mmio && off[3:2] == 2'd2) m_ws = d[3:0];
    end
    if (!is_ram && !is_mmio) m_err = 1'b1;
    chk("leds", {24'h0, leds_o}, {24'h0, m_leds});
    chk("bus_err", {31'h0, bus_err_o}, {31'h0, m_err});
  endtask

  logic [31:0] rv, r1, r2, t1, a, d;
  int          sel, kind;

  initial begin
    rst = 1'b1; rd_en_i = 1'b0; wr_en_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    m_leds = 8'h0; m_ws = 4'(WS0); m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_rd_strobe", {31'h0, mem_rd_en_o}, 32'h0);
    chk("rst_wr_strobe", {31'h0, mem_wr_en_o}, 32'h0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_leds", {24'h0, leds_o}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: RAM read/write, WS CSR, MMIO, unmapped, simultaneous request
    txn(1, 0, 32'h10, 32'h0, rv);
    txn(0, 1, 32'h20, 32'h12345678, rv);
    txn(1, 0, 32'h20, 32'h0, rv);
    txn(0, 1, MB + 8, 32'h0, rv);
    txn(1, 0, 32'h10, 32'h0, rv);
    txn(0, 1, MB + 8, 32'hF, rv);
    txn(1, 0, 32'h20, 32'h0, rv);
    txn(0, 1, MB + 8, 32'h1, rv);
    txn(1, 0, MB + 8, 32'h0, rv);
    txn(0, 1, MB, 32'hA5, rv);
    txn(1, 0, MB + 4, 32'h0, r1);
    t1 = t_issue;
    repeat (7) @(negedge clk);
    txn(1, 0, MB + 5, 32'h0, r2);
    chk("cycle_delta", r2 - r1, t_issue - t1);
    txn(0, 1, MB + 4, 32'hFFFF, rv);
    txn(1, 0, MB + 4, 32'h0, rv);
    txn(1, 0, MB + 32'hC, 32'h0, rv);
    txn(0, 1, MB + 32'hC, 32'h55, rv);
    txn(1, 0, 32'h2000, 32'h0, rv);
    txn(1, 1, 32'h30, 32'hCAFEF00D, rv);
    txn(1, 0, 32'h30, 32'h0, rv);

    // Randomized mix over RAM, MMIO window and arbitrary addresses
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1:    a = $urandom_range(0, 63) << 2;
        2:       a = MB + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      d = $urandom;
      if (a - MB < 32'd16) d = d & ~32'hC;
      sel = int'($urandom_range(0, 2));
      txn(sel != 1, sel != 0, a, d, rv);
    end

    // Reset during WAIT: abort, registers back to reset values
    txn(0, 1, MB, 32'h3C, rv);
    txn(1, 0, 32'h0, 32'h0, rv);
    txn(0, 1, MB + 8, 32'h5, rv);
    rd_en_i = 1'b1; addr_i = 32'h10;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", {31'h0, ack_o}, 32'h0);
    chk("midrst_strobe", {30'h0, mem_rd_en_o, mem_wr_en_o}, 32'h0);
    chk("midrst_leds", {24'h0, leds_o}, 32'h0);
    chk("midrst_bus_err", {31'h0, bus_err_o}, 32'h0);
    rst = 1'b0; rd_en_i = 1'b0;
    m_leds = 8'h0; m_ws = 4'(WS0); m_err = 1'b0;
    @(negedge clk);
    txn(1, 0, 32'h20, 32'h0, rv);
    txn(1, 0, MB + 8, 32'h0, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Parametrised bus bridge between the core's load/store port and the synchronous word memory. It replaces the hard-wired `ack = 1` connection with a real request/acknowledge handshake and programmable wait states. It also decodes a small MMIO register window (LED register, cycle counter, wait-state CSR) and flags accesses to unmapped addresses.

## Interface
- `DATA_WIDTH`, default 32: data bus width; the MMIO registers are zero-extended to this width.
- `ADDR_WIDTH`, default 32: address width.
- `MEM_SIZE`, default 4096: RAM size in bytes; RAM occupies `[0, MEM_SIZE)`.
- `MMIO_BASE`, default 32'h8000_0000: base of the 16-byte MMIO window.
- `WAIT_STATES`, default 1: reset value of the wait-state CSR (range 0-15).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en_i`  in  1  core read request.
- `wr_en_i`  in  1  core write request.
- `addr_i`  in  ADDR_WIDTH  core byte address.
- `data_i`  in  DATA_WIDTH  core write data.
- `data_o`  out  DATA_WIDTH  read data; valid only while `ack_o`=1.
- `ack_o`  out  1  one-cycle transaction acknowledge.
- `mem_rd_en_o`  out  1  memory read strobe.
- `mem_wr_en_o`  out  1  memory write strobe.
- `mem_addr_o`  out  ADDR_WIDTH  memory address (latched `addr_i`).
- `mem_data_o`  out  DATA_WIDTH  memory write data (latched `data_i`).
- `mem_data_i`  in  DATA_WIDTH  memory read data; valid the cycle after `mem_rd_en_o`.
- `leds_o`  out  8  LED register contents.
- `bus_err_o`  out  1  sticky flag: an unmapped access has occurred.

## Operation
- FSM states: IDLE → ACCESS → LATCH → WAIT (0..15 cycles) → RESP → IDLE.
- **IDLE**
  - If `rd_en_i|wr_en_i`, latch the address, data and type, then go to ACCESS.
  - If both `rd_en_i` and `wr_en_i` are high, the request is a write.
  - Requests arriving in any other state are ignored. The core holds its request until `ack_o`.
- **Address decode** on the latched address, in priority order:
  - RAM: `addr < MEM_SIZE`.
  - MMIO: `MMIO_BASE <= addr < MMIO_BASE+16`. Offset is `addr[3:2]`; `addr[1:0]` is ignored.
  - Otherwise the access is unmapped.
- **ACCESS** (exactly one cycle)
  - RAM: pulse `mem_rd_en_o` or `mem_wr_en_o`.
  - MMIO write: the register updates at the end of this cycle.
  - Load the wait counter from `ws_q`.
- **LATCH** (one cycle)
  - RAM read: capture `mem_data_i` into `rdata_q`.
  - MMIO read: capture the register value into `rdata_q`.
  - Unmapped read: capture 0.
  - Write: `rdata_q` is unchanged.
- **WAIT**: decrement the counter until it reaches 0. With `ws_q`=0 the FSM skips WAIT and goes from LATCH straight to RESP.
- **RESP**: `ack_o`=1 and `data_o`=`rdata_q` for exactly one cycle, then IDLE.
- **MMIO map** (byte offsets from `MMIO_BASE`)
  - 0x0 LED: RW, 8 bits, reset 0.
  - 0x4 CYCLE: RO, free-running 32-bit counter, increments every cycle, wraps at 2^32. Writes are ignored.
  - 0x8 WS: RW, 4 bits, reset `WAIT_STATES`. A write affects the next transaction only.
  - 0xC: reserved; reads 0, writes are ignored.
- **Unmapped access**: no memory strobe, read data is 0, and `bus_err_o` sets and stays set until `rst`. The access is still acknowledged with normal timing.
- Memory strobes never assert outside ACCESS, and never for MMIO or unmapped accesses.

## Timing
- Request first seen in IDLE at cycle T:
  - ACCESS at T+1.
  - LATCH at T+2.
  - `ack_o` at T+3+`ws_q`.
- Throughput: one transaction per 4+`ws_q` cycles.
- A request still asserted in the cycle after RESP is accepted as a new transaction.
- Reset values:
  - `ack_o`=0, `mem_rd_en_o`=0, `mem_wr_en_o`=0.
  - `data_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `leds_o`=0, `bus_err_o`=0.
  - CYCLE=0, WS=`WAIT_STATES`, FSM in IDLE.
- Reset asserted mid-transaction:
  - Abort; in the next cycle there is no ack and no strobe.
  - The FSM is in IDLE on the first cycle after `rst` deasserts.
  - An MMIO write already committed in ACCESS stays overwritten by its reset value.
- CYCLE wrap: 32'hFFFF_FFFF → 0 with no side effect.

## Test plan
- **RAM read, WS=1**: preload word 0x10=32'hDEADBEEF; `rd_en_i`=1, `addr_i`=0x10 at T → `mem_rd_en_o` high only at T+1; `ack_o` at T+4 with `data_o`=32'hDEADBEEF.
- **RAM write then read back**: write 32'h12345678 to 0x20 → `mem_wr_en_o` pulses once with `mem_addr_o`=0x20; a subsequent read of 0x20 returns 32'h12345678.
- **Wait-state CSR**:
  - Write 0 to MMIO_BASE+8 → next RAM read acks at T+3.
  - Write 15 → next RAM read acks at T+18.
  - The write transaction itself uses the old WS.
- **MMIO**:
  - Write 32'hA5 to MMIO_BASE → `leds_o`=8'hA5.
  - Two reads of MMIO_BASE+4 spaced N cycles apart return values differing by N.
  - A read of MMIO_BASE+0xC returns 0.
- **Unmapped / simultaneous**:
  - Read 0x2000 (`MEM_SIZE`=4096) → no strobe, `data_o`=0, `bus_err_o`=1, ack at normal latency.
  - `rd_en_i`=`wr_en_i`=1 → write performed.
- **Reset mid-operation**: assert `rst` during WAIT → next cycle `ack_o`=0, `leds_o`=0, `bus_err_o`=0; a new read after reset completes normally.
